kick_pulse_gen: RTL

Downstream consumer of the FSMC command buffer's `strength` and `shoot_enable` outputs. It converts a kick request into a single timed gate pulse on the flat-kick or chip-kick driver. A pulse fires only when the ball is detected and the capacitor bank is charged, and a mandatory recharge cooldown follows each kick. It sits between the command buffer and the boost/kicker IGBT gate pins.

---
 rtl/kick_pulse_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/kick_pulse_gen.sv
// Kick request to timed gate pulse on the flat or chip kicker, gated by ball presence and
// capacitor charge, followed by a forced recharge cooldown.
module kick_pulse_gen #(
  parameter int unsigned TICK_DIV          = 50,
  parameter int unsigned PULSE_UNIT        = 10,
  parameter int unsigned MAX_STRENGTH      = 127,
  parameter int unsigned COOLDOWN_TICKS    = 500000,
  parameter int unsigned ARM_TIMEOUT_TICKS = 2000000
) (
  input  logic       clk0,
  input  logic       rst_n,
  input  logic [7:0] strength,
  input  logic       shoot_enable,
  input  logic       kick_mode,
  input  logic       infrared,
  input  logic       cap_ready,
  output logic       kick_flat,
  output logic       kick_chip,
  output logic       busy,
  output logic       kick_done,
  output logic [7:0] kick_count
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam logic [7:0] StrMax = 8'(MAX_STRENGTH);

  typedef enum logic [1:0] {StIdle, StArmed, StFire, StCooldown} state_e;

  logic [1:0] se_sync, km_sync, ir_sync, cr_sync;
  logic       se_prev;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      se_sync <= 2'b00;
      km_sync <= 2'b00;
      ir_sync <= 2'b00;
      cr_sync <= 2'b00;
      se_prev <= 1'b0;
    end else begin
      se_sync <= {se_sync[0], shoot_enable};
      km_sync <= {km_sync[0], kick_mode};
      ir_sync <= {ir_sync[0], infrared};
      cr_sync <= {cr_sync[0], cap_ready};
      se_prev <= se_sync[1];
    end
  end

  state_e          state_q;
  logic [PreW-1:0] pre_q;
  logic [31:0]     cnt_q;
  logic [7:0]      s_q;
  logic            mode_q;

  logic            se, se_rise, fire_ok, tick, last_tick;
  logic [7:0]      strength_clamped;
  logic [15:0]     pulse_ticks;

  always_comb begin
    se               = se_sync[1];
    se_rise          = se_sync[1] & ~se_prev;
    fire_ok          = ir_sync[1] & cr_sync[1];
    tick             = (pre_q == PreMax);
    last_tick        = tick && (cnt_q == 32'd1);
    strength_clamped = (strength > StrMax) ? StrMax : strength;
    pulse_ticks      = 16'(s_q) * 16'(PULSE_UNIT);
  end

  // Every state change clears the prescaler so each duration is a whole number of ticks.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pre_q      <= '0;
      cnt_q      <= '0;
      s_q        <= '0;
      mode_q     <= 1'b0;
      kick_flat  <= 1'b0;
      kick_chip  <= 1'b0;
      busy       <= 1'b0;
      kick_done  <= 1'b0;
      kick_count <= '0;
    end else begin
      kick_done <= 1'b0;
      case (state_q)
        StIdle: begin
          pre_q <= '0;
          if (se_rise && (strength != 8'd0)) begin
            state_q <= StArmed;
            s_q     <= strength_clamped;
            mode_q  <= km_sync[1];
            cnt_q   <= 32'(ARM_TIMEOUT_TICKS);
            busy    <= 1'b1;
          end
        end
        StArmed: begin
          if (!se) begin
            state_q <= StIdle;
            pre_q   <= '0;
            busy    <= 1'b0;
          end else if (fire_ok) begin
            state_q   <= StFire;
            pre_q     <= '0;
            cnt_q     <= {16'd0, pulse_ticks};
            kick_flat <= ~mode_q;
            kick_chip <= mode_q;
          end else if (last_tick) begin
            state_q <= StIdle;
            pre_q   <= '0;
            busy    <= 1'b0;
          end else begin
            pre_q <= tick ? '0 : pre_q + PreW'(1);
            cnt_q <= tick ? cnt_q - 32'd1 : cnt_q;
          end
        end
        StFire: begin
          if (last_tick) begin
            state_q    <= StCooldown;
            pre_q      <= '0;
            cnt_q      <= 32'(COOLDOWN_TICKS);
            kick_flat  <= 1'b0;
            kick_chip  <= 1'b0;
            kick_done  <= 1'b1;
            kick_count <= kick_count + 8'd1;
          end else begin
            pre_q <= tick ? '0 : pre_q + PreW'(1);
            cnt_q <= tick ? cnt_q - 32'd1 : cnt_q;
          end
        end
        StCooldown: begin
          if (last_tick) begin
            state_q <= StIdle;
            pre_q   <= '0;
            busy    <= 1'b0;
          end else begin
            pre_q <= tick ? '0 : pre_q + PreW'(1);
            cnt_q <= tick ? cnt_q - 32'd1 : cnt_q;
          end
        end
        default: begin
          state_q   <= StIdle;
          pre_q     <= '0;
          kick_flat <= 1'b0;
          kick_chip <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
